// File: rtl/cim_bitserial_sched_if.sv
// cim_bitserial_sched_if
//   Bundles the signals that pass between the bit-serial job scheduler and the rest of the system.
//   Job input  : in_valid / in_ready / in_row / in_act (32 x 4-bit activations)
//   Macro side : cim_en / cim_row / cim_plane / cim_bit, result back on acc_valid / acc_result
//   Result out : out_valid / out_ready / out_data / out_row
//   The slave modport is the scheduler's view. The master modport is the view of the
//   surrounding environment (job source, adder tree and result consumer).
interface cim_bitserial_sched_if #(
  parameter int ROW_W = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic [127:0]     in_act;
  logic             cim_en;
  logic [ROW_W-1:0] cim_row;
  logic [1:0]       cim_plane;
  logic [31:0]      cim_bit;
  logic             acc_valid;
  logic [12:0]      acc_result;
  logic             out_valid;
  logic             out_ready;
  logic [12:0]      out_data;
  logic [ROW_W-1:0] out_row;

  modport slave (
    input  in_valid, in_row, in_act, acc_valid, acc_result, out_ready,
    output in_ready, cim_en, cim_row, cim_plane, cim_bit, out_valid, out_data, out_row
  );

  modport master (
    output in_valid, in_row, in_act, acc_valid, acc_result, out_ready,
    input  in_ready, cim_en, cim_row, cim_plane, cim_bit, out_valid, out_data, out_row
  );
endinterface

// File: rtl/cim_bitserial_sched.sv
// cim_bitserial_sched
//   Job controller for the 32-input CIM bit-serial adder-tree path. The scheduler accepts one
//   job (row + 32 unsigned 4-bit activations) and drives the four bit-planes MSB first. It then
//   waits for the 13-bit accumulated result and returns that result through a 2-entry queue.
//   Ports:
//     clk, rst_n   : rising-edge clock, asynchronous active-low reset
//     bus          : cim_bitserial_sched_if.slave (job in, macro drive, tree result, result out)
//     busy         : scheduler is not idle
//     err_timeout  : sticky flag, a job was abandoned because no result arrived
//   cim_bitserial_sched_chk holds the structural checks. The top level instantiates it.

module cim_bitserial_sched_chk #(
  parameter int ROW_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_issue,
  input logic             in_wait,
  input logic             cim_en,
  input logic             push,
  input logic             accept,
  input logic [ROW_W-1:0] in_row,
  input logic [ROW_W-1:0] push_row
);
  logic [ROW_W-1:0] acc_row_q;

  // Remember the row of the job currently in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_row_q <= {ROW_W{1'b0}};
    end else if (accept) begin
      acc_row_q <= in_row;
    end
  end

  a_en_only_issue : assert property (@(posedge clk) disable iff (!rst_n) cim_en |-> in_issue);
  a_push_row      : assert property (@(posedge clk) disable iff (!rst_n) push |-> (push_row == acc_row_q));
  a_push_in_wait  : assert property (@(posedge clk) disable iff (!rst_n) push |-> in_wait);
endmodule

module cim_bitserial_sched #(
  parameter int ROW_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cim_bitserial_sched_if.slave  bus,
  output logic                  busy,
  output logic                  err_timeout
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = ROW_W + 13;

  // Gather bit 'plane' of each of the 32 activation nibbles
  function automatic logic [31:0] plane_bits(input logic [127:0] act, input logic [1:0] plane);
    logic [127:0] sh;
    logic [31:0]  bits;
    sh   = act >> plane;
    bits = 32'd0;
    for (int k = 0; k < 32; k++) begin
      bits[k] = sh[4*k];
    end
    return bits;
  endfunction

  state_e           state_q, state_d;
  logic [127:0]     act_q, act_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       plane_q, plane_d;
  logic             cim_en_q, cim_en_d;
  logic [31:0]      cim_bit_q, cim_bit_d;
  logic [CNT_W-1:0] wait_q, wait_d, wait_inc_s;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       qcount_q, qcount_d;
  logic [ENT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ENT_W-1:0] entry_s;
  logic             push_s, pop_s, accept_s;

  assign accept_s = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
  assign pop_s    = out_valid_q && bus.out_ready;
  assign entry_s  = {row_q, bus.acc_result};

  // Job sequencing: accept, four MSB-first planes, then bounded wait for the tree result
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cim_en_d   = cim_en_q;
    cim_bit_d  = cim_bit_q;
    wait_d     = wait_q;
    err_d      = err_q;
    push_s     = 1'b0;
    wait_inc_s = wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // The first plane is driven straight from the incoming activations, so it
          // appears the cycle after accept.
          state_d   = ST_ISSUE;
          act_d     = bus.in_act;
          row_d     = bus.in_row;
          plane_d   = 2'd3;
          cim_en_d  = 1'b1;
          cim_bit_d = plane_bits(bus.in_act, 2'd3);
        end else begin
          cim_en_d  = 1'b0;
          cim_bit_d = 32'd0;
        end
      end
      ST_ISSUE: begin
        if (plane_q == 2'd0) begin
          state_d   = ST_WAIT;
          cim_en_d  = 1'b0;
          cim_bit_d = 32'd0;
          wait_d    = {CNT_W{1'b0}};
        end else begin
          plane_d   = plane_q - 2'd1;
          cim_bit_d = plane_bits(act_q, plane_q - 2'd1);
        end
      end
      ST_WAIT: begin
        wait_d = wait_inc_s;
        // A result on the last allowed cycle still wins over the timeout
        if (bus.acc_valid) begin
          push_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_inc_s == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cim_en_d  = 1'b0;
        cim_bit_d = 32'd0;
      end
    endcase
  end

  // Two-entry result queue; head_q always holds the oldest entry
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    qcount_d = qcount_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (qcount_q == 2'd0) begin
          head_d = entry_s;
        end else begin
          tail_d = entry_s;
        end
        qcount_d = qcount_q + 2'd1;
      end
      2'b01: begin
        head_d   = tail_q;
        qcount_d = qcount_q - 2'd1;
      end
      2'b11: begin
        if (qcount_q == 2'd1) begin
          head_d = entry_s;
        end else begin
          head_d = tail_q;
          tail_d = entry_s;
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Status outputs are decoded from next-state values so they are registered yet current
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE) && (qcount_d != 2'd2);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (qcount_d != 2'd0);
  end

  // All state, job and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      act_q       <= 128'd0;
      row_q       <= {ROW_W{1'b0}};
      plane_q     <= 2'd0;
      cim_en_q    <= 1'b0;
      cim_bit_q   <= 32'd0;
      wait_q      <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      qcount_q    <= 2'd0;
      head_q      <= {ENT_W{1'b0}};
      tail_q      <= {ENT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      cim_en_q    <= cim_en_d;
      cim_bit_q   <= cim_bit_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      qcount_q    <= qcount_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cim_en    = cim_en_q;
  assign bus.cim_row   = row_q;
  assign bus.cim_plane = plane_q;
  assign bus.cim_bit   = cim_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_q[12:0];
  assign bus.out_row   = head_q[ENT_W-1:13];
  assign busy          = busy_q;
  assign err_timeout   = err_q;

  cim_bitserial_sched_chk #(.ROW_W(ROW_W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_issue (state_q == ST_ISSUE),
    .in_wait  (state_q == ST_WAIT),
    .cim_en   (cim_en_q),
    .push     (push_s),
    .accept   (accept_s),
    .in_row   (bus.in_row),
    .push_row (row_q)
  );
endmodule
